// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default widths for the parametrised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // The counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port RAM with synchronous write and a registered read port.
// On an address collision the read returns the word stored before the write.
module fifo_mem_sdp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Only the output register is reset; storage keeps stale contents.
  always_ff @(posedge clk) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy counter, status flags
// and sticky error flags around a simple dual-port RAM.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int PTR_W   = clog2(DEPTH),
  localparam int CNT_W   = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  fifo_counter,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, overflow_q, underflow_q;
  logic             rd_acc, wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));

  // A write into a full FIFO is only legal when a read frees a slot this cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= rd_acc;
      overflow_q  <= overflow_q  | (wr_en & ~wr_acc);
      underflow_q <= underflow_q | (rd_en & ~rd_acc);
    end
  end

  fifo_mem_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc & ~rst),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign data_valid   = valid_q;
  assign fifo_counter = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed vector table, hand-written
// corner sequences and random traffic, all compared against a queue model.
module tb_sync_fifo_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] dataIn = '0;
  logic              wrEn = 1'b0;
  logic              rdEn = 1'b0;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic [CNT_W-1:0]  fifoCounter;
  logic              empty, full, almostEmpty, almostFull, overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (dataIn),
    .wr_en        (wrEn),
    .rd_en        (rdEn),
    .data_out     (dataOut),
    .data_valid   (dataValid),
    .fifo_counter (fifoCounter),
    .empty        (empty),
    .full         (full),
    .almost_empty (almostEmpty),
    .almost_full  (almostFull),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Reference model: the FIFO contents as a plain queue plus output registers.
  logic [DATA_W-1:0] modelQ [$];
  logic [DATA_W-1:0] modelDout = '0;
  logic              modelDv = 1'b0, modelOvf = 1'b0, modelUnf = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic              r, w, rd;
    logic [DATA_W-1:0] din;
    int                expCount;
    logic              expEmpty, expAe, expDv;
    logic [DATA_W-1:0] expDout;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input logic r, input logic w, input logic rd, input logic [DATA_W-1:0] d);
    bit rdAcc, wrAcc;
    if (r) begin
      modelQ.delete();
      modelDout = '0;
      modelDv   = 1'b0;
      modelOvf  = 1'b0;
      modelUnf  = 1'b0;
    end else begin
      rdAcc = rd && (modelQ.size() > 0);
      wrAcc = w && ((modelQ.size() < DEPTH) || rdAcc);
      modelDv = rdAcc;
      if (rdAcc) modelDout = modelQ.pop_front();
      if (w && !wrAcc) modelOvf = 1'b1;
      if (rd && !rdAcc) modelUnf = 1'b1;
      if (wrAcc) modelQ.push_back(d);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = modelQ.size();
    check({tag, ".dout"},  dataOut,     modelDout);
    check({tag, ".dv"},    dataValid,   modelDv);
    check({tag, ".count"}, fifoCounter, n);
    check({tag, ".empty"}, empty,       n == 0);
    check({tag, ".full"},  full,        n == DEPTH);
    check({tag, ".ae"},    almostEmpty, n <= AE);
    check({tag, ".af"},    almostFull,  n >= AF);
    check({tag, ".ovf"},   overflow,    modelOvf);
    check({tag, ".unf"},   underflow,   modelUnf);
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic rd,
                               input logic [DATA_W-1:0] d, input string tag);
    @(negedge clk);
    rst = r; wrEn = w; rdEn = rd; dataIn = d;
    @(posedge clk);
    modelStep(r, w, rd, d);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    // Directed table: reset, write 0x11..0x16, read them back.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      vecs[1 + i] = '{1'b0, 1'b1, 1'b0, 32'h11 + i, i + 1, 1'b0, (i + 1) <= 2, 1'b0, 32'h0};
      vecs[7 + i] = '{1'b0, 1'b0, 1'b1, 32'h0, 5 - i, (5 - i) == 0, (5 - i) <= 2, 1'b1, 32'h11 + i};
    end

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].din, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tcount", i), fifoCounter, vecs[i].expCount);
      check($sformatf("vec%0d.tempty", i), empty,       vecs[i].expEmpty);
      check($sformatf("vec%0d.tae", i),    almostEmpty, vecs[i].expAe);
      check($sformatf("vec%0d.tdv", i),    dataValid,   vecs[i].expDv);
      check($sformatf("vec%0d.tdout", i),  dataOut,     vecs[i].expDout);
    end

    // Fill to full, then one rejected write.
    applyStimulus(1, 0, 0, 0, "t2rst");
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 32'h100 + i, "t2fill");
    applyStimulus(0, 1, 0, 32'hDEAD, "t2extra");
    check("t2.full", full, 1);
    check("t2.count", fifoCounter, DEPTH);
    check("t2.ovf", overflow, 1);
    applyStimulus(0, 0, 0, 0, "t2idle");
    check("t2.ovfSticky", overflow, 1);
    applyStimulus(0, 0, 1, 0, "t2read");
    check("t2.firstWord", dataOut, 32'h100);

    // Full FIFO with simultaneous read and write.
    applyStimulus(1, 0, 0, 0, "t3rst");
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 32'h200 + i, "t3fill");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 32'hA0 + i, "t3rw");
      check("t3.count", fifoCounter, DEPTH);
      check("t3.full", full, 1);
      check("t3.ovf", overflow, 0);
      check("t3.dout", dataOut, 32'h200 + i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 1, 0, "t3drain");
      if (i >= DEPTH - 4) check("t3.tail", dataOut, 32'hA0 + i - (DEPTH - 4));
    end

    // Empty FIFO with simultaneous read and write: write only.
    applyStimulus(1, 0, 0, 0, "t4rst");
    applyStimulus(0, 1, 1, 32'h55, "t4rw");
    check("t4.unf", underflow, 1);
    check("t4.dv", dataValid, 0);
    check("t4.count", fifoCounter, 1);
    applyStimulus(0, 0, 1, 0, "t4read");
    check("t4.dout", dataOut, 32'h55);

    // Streaming across pointer wrap.
    applyStimulus(1, 0, 0, 0, "t5rst");
    applyStimulus(0, 1, 0, 32'h1000, "t5prime");
    for (int i = 0; i < 3 * DEPTH; i++) begin
      applyStimulus(0, 1, 1, 32'h1001 + i, "t5stream");
      check("t5.count", fifoCounter, 1);
      check("t5.dout", dataOut, 32'h1000 + i);
    end

    // Reset mid-operation with both error flags set.
    applyStimulus(1, 0, 0, 0, "t6rst");
    applyStimulus(0, 0, 1, 0, "t6unf");
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 1, 0, 32'h300 + i, "t6fill");
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, "t6read");
    check("t6.pre.count", fifoCounter, 9);
    check("t6.pre.flags", {overflow, underflow}, 2'b11);
    applyStimulus(1, 1, 1, 32'hBAD, "t6midrst");
    check("t6.count", fifoCounter, 0);
    check("t6.empty", empty, 1);
    check("t6.flags", {overflow, underflow, dataValid}, 3'b000);
    applyStimulus(0, 1, 0, 32'h77, "t6wr");
    applyStimulus(0, 0, 1, 0, "t6rd");
    check("t6.newData", dataOut, 32'h77);
    check("t6.drained", empty, 1);

    // Random traffic in phases biased towards filling, draining and balance.
    for (int i = 0; i < 900; i++) begin
      int wBias;
      logic r, w, rd;
      wBias = (i / 150) % 3 == 0 ? 80 : ((i / 150) % 3 == 1 ? 20 : 50);
      r  = ($urandom_range(0, 99) < 2);
      w  = ($urandom_range(0, 99) < wBias);
      rd = ($urandom_range(0, 99) < (100 - wBias));
      applyStimulus(r, w, rd, $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
